// File: rtl/dac_level_ctrl.sv
// DAC setpoint controller: saturating setpoint updates, ON/OFF sequencing, DAC write strobes.
// Optional macro DAC_LEVEL_CTRL_RAMP_EN enables the one-LSB-per-tick slew; otherwise the code jumps.
`timescale 1ns/1ps
module dac_level_ctrl #(
  parameter int AMOUNT_WIDTH = 8,
  parameter int DAC_WIDTH    = 12,
  parameter int RAMP_DIV     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  input  logic                    on,
  input  logic                    off,
  input  logic                    increase,
  input  logic                    decrease,
  input  logic [AMOUNT_WIDTH-1:0] amount,
  output logic [DAC_WIDTH-1:0]    dac_code,
  output logic                    dac_wr,
  output logic                    out_en,
  output logic                    busy,
  output logic                    sat
);

  typedef enum logic [1:0] {S_OFF, S_IDLE, S_RAMP, S_RAMP_DOWN} state_t;

  state_t               r_state;
  logic [DAC_WIDTH-1:0] r_target;
  logic [DAC_WIDTH-1:0] r_code;
  logic                 r_cmd_valid_q;
  logic                 r_dac_wr;
  logic                 r_out_en;
  logic                 r_sat;

  logic                 w_accept;
  logic                 w_on_req;
  logic                 w_off_req;
  logic [DAC_WIDTH:0]   w_amt_ext;
  logic [DAC_WIDTH:0]   w_sum;
  logic [DAC_WIDTH:0]   w_diff;
  logic [DAC_WIDTH-1:0] w_target_next;
  logic                 w_clamp;
  logic                 w_down;
  logic [DAC_WIDTH-1:0] w_goal;
  logic [DAC_WIDTH-1:0] w_step;
  logic                 w_tick;
  state_t               w_done_state;
  state_t               w_stay_state;

  assign w_accept  = cmd_valid & ~r_cmd_valid_q;
  assign w_on_req  = w_accept & on & ~off;
  assign w_off_req = w_accept & off & ~on;
  assign w_amt_ext = (DAC_WIDTH+1)'(amount);
  assign w_sum     = {1'b0, r_target} + w_amt_ext;
  assign w_diff    = {1'b0, r_target} - w_amt_ext;

  // Extra MSB of sum/difference flags overflow/underflow for the clamp.
  always_comb begin
    w_target_next = r_target;
    w_clamp       = 1'b0;
    if (w_accept && increase && !decrease) begin
      if (w_sum[DAC_WIDTH]) begin
        w_target_next = '1;
        w_clamp       = 1'b1;
      end else begin
        w_target_next = w_sum[DAC_WIDTH-1:0];
      end
    end else if (w_accept && decrease && !increase) begin
      if (w_diff[DAC_WIDTH]) begin
        w_target_next = '0;
        w_clamp       = 1'b1;
      end else begin
        w_target_next = w_diff[DAC_WIDTH-1:0];
      end
    end
  end

  // Direction of travel for this cycle, after any on/off request in the same command.
  assign w_down = ((r_state == S_RAMP_DOWN) && !w_on_req) || ((r_state == S_RAMP) && w_off_req);
  assign w_goal = w_down ? '0 : w_target_next;
  assign w_done_state = w_down ? S_OFF : S_IDLE;
  assign w_stay_state = w_down ? S_RAMP_DOWN : S_RAMP;

`ifdef DAC_LEVEL_CTRL_RAMP_EN
  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0] RELOAD = PW'(RAMP_DIV - 1);

  logic [PW-1:0] r_prescaler;

  assign w_tick = (r_prescaler == '0);
  assign w_step = (r_code < w_goal) ? r_code + DAC_WIDTH'(1) : r_code - DAC_WIDTH'(1);
  assign busy   = (r_state == S_RAMP) || (r_state == S_RAMP_DOWN);
`else
  assign w_tick = (RAMP_DIV >= 1);
  assign w_step = w_goal;
  assign busy   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_OFF;
      r_target      <= '0;
      r_code        <= '0;
      r_cmd_valid_q <= 1'b0;
      r_dac_wr      <= 1'b0;
      r_out_en      <= 1'b0;
      r_sat         <= 1'b0;
`ifdef DAC_LEVEL_CTRL_RAMP_EN
      r_prescaler   <= '0;
`endif
    end else begin
      r_cmd_valid_q <= cmd_valid;
      r_target      <= w_target_next;
      r_sat         <= w_clamp;
      r_dac_wr      <= 1'b0;
      case (r_state)
        S_OFF: begin
          r_out_en <= 1'b0;
          if (w_on_req) begin
            r_out_en <= 1'b1;
            if (w_target_next != '0) begin
              r_state <= S_RAMP;
`ifdef DAC_LEVEL_CTRL_RAMP_EN
              r_prescaler <= RELOAD;
`endif
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_IDLE: begin
          if (w_off_req) begin
            if (r_code == '0) begin
              r_state <= S_OFF;
            end else begin
              r_state <= S_RAMP_DOWN;
`ifdef DAC_LEVEL_CTRL_RAMP_EN
              r_prescaler <= RELOAD;
`endif
            end
          end else if (w_target_next != r_code) begin
            r_state <= S_RAMP;
`ifdef DAC_LEVEL_CTRL_RAMP_EN
            r_prescaler <= RELOAD;
`endif
          end
        end
        default: begin
`ifdef DAC_LEVEL_CTRL_RAMP_EN
          r_prescaler <= w_tick ? RELOAD : r_prescaler - PW'(1);
`endif
          if (r_code == w_goal) begin
            r_state <= w_done_state;
          end else if (w_tick) begin
            r_code   <= w_step;
            r_dac_wr <= 1'b1;
            r_state  <= (w_step == w_goal) ? w_done_state : w_stay_state;
          end else begin
            r_state <= w_stay_state;
          end
        end
      endcase
    end
  end

  assign dac_code = r_code;
  assign dac_wr   = r_dac_wr;
  assign out_en   = r_out_en;
  assign sat      = r_sat;

endmodule

// File: tb/tb_dac_level_ctrl.sv
// Scoreboard bench for dac_level_ctrl: expected DAC codes are queued per command and
// popped by a monitor on every dac_wr strobe. Works with or without DAC_LEVEL_CTRL_RAMP_EN.
`timescale 1ns/1ps
module tb_dac_level_ctrl;
  localparam int AW = 8;
  localparam int DW = 12;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          on = 1'b0;
  logic          off = 1'b0;
  logic          increase = 1'b0;
  logic          decrease = 1'b0;
  logic [AW-1:0] amount = '0;
  logic [DW-1:0] dac_code;
  logic          dac_wr;
  logic          out_en;
  logic          busy;
  logic          sat;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int last_wr_cyc = 0;
  int sat_cnt = 0;
  int exp_sat = 0;
  int acc_cyc = 0;
  int exp_q[$];

  dac_level_ctrl #(.AMOUNT_WIDTH(AW), .DAC_WIDTH(DW), .RAMP_DIV(RD)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .on(on), .off(off),
    .increase(increase), .decrease(decrease), .amount(amount),
    .dac_code(dac_code), .dac_wr(dac_wr), .out_en(out_en), .busy(busy), .sat(sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected strobe count / last-step latency for a move of n LSB.
  function automatic int exp_wr(input int n);
`ifdef DAC_LEVEL_CTRL_RAMP_EN
    return n;
`else
    return (n != 0) ? 1 : 0;
`endif
  endfunction

  function automatic int exp_lat(input int n);
`ifdef DAC_LEVEL_CTRL_RAMP_EN
    return n * RD;
`else
    return (n != 0) ? 1 : 0;
`endif
  endfunction

  task automatic push_move(input int from, input int to);
`ifdef DAC_LEVEL_CTRL_RAMP_EN
    if (to > from) for (int v = from + 1; v <= to; v++) exp_q.push_back(v);
    else for (int v = from - 1; v >= to; v--) exp_q.push_back(v);
`else
    if (from != to) exp_q.push_back(to);
`endif
  endtask

  // Monitor: every dac_wr must match the head of the scoreboard queue.
  always @(negedge clk) begin
    if (dac_wr) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_dac_wr", int'(dac_code), -1);
      end else begin
        chk("dac_code_on_wr", int'(dac_code), exp_q.pop_front());
      end
    end
    if (sat) sat_cnt++;
  end

  task automatic cmd(input bit c_on, input bit c_off, input bit c_inc, input bit c_dec, input int amt);
    @(negedge clk);
    on = c_on; off = c_off; increase = c_inc; decrease = c_dec;
    amount = AW'(amt); cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; on = 1'b0; off = 1'b0; increase = 1'b0; decrease = 1'b0; amount = '0;
    acc_cyc = cyc;
    $display("cmd cyc=%0d on=%0b off=%0b inc=%0b dec=%0b amt=%0d code=%0d",
             acc_cyc, c_on, c_off, c_inc, c_dec, amt, dac_code);
    @(negedge clk);
  endtask

  task automatic wait_drain(input int budget, input string name);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({name, "_drain_timeout"}, int'(done), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_code(input int v, input int budget, input string name);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (int'(dac_code) == v) begin
        done = 1'b1;
        break;
      end
    end
    chk({name, "_code_timeout"}, int'(done), 1);
  endtask

  initial begin
    int w0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_code", int'(dac_code), 0);
    chk("rst_out_en", int'(out_en), 0);
    chk("rst_dac_wr", int'(dac_wr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sat", int'(sat), 0);
    rst = 1'b0;

    // A: on + increase 10 from reset
    w0 = wr_cnt;
    push_move(0, 10);
    cmd(1, 0, 1, 0, 10);
    chk("A_out_en", int'(out_en), 1);
`ifdef DAC_LEVEL_CTRL_RAMP_EN
    chk("A_busy_ramp", int'(busy), 1);
`else
    chk("A_busy_ramp", int'(busy), 0);
`endif
    wait_drain(200, "A");
    chk("A_code", int'(dac_code), 10);
    chk("A_wr_count", wr_cnt - w0, exp_wr(10));
    chk("A_latency", last_wr_cyc - acc_cyc, exp_lat(10));
    chk("A_busy_done", int'(busy), 0);

    // B: decrease to 5, then decrease 9 clamps at 0 with out_en kept
    push_move(10, 5);
    cmd(0, 0, 0, 1, 5);
    wait_drain(200, "B1");
    chk("B1_code", int'(dac_code), 5);
    push_move(5, 0);
    exp_sat++;
    cmd(0, 0, 0, 1, 9);
    wait_drain(200, "B2");
    chk("B2_code", int'(dac_code), 0);
    chk("B2_out_en", int'(out_en), 1);
    chk("B2_sat_count", sat_cnt, exp_sat);

    // C: cmd_valid held 100 cycles applies increase 3 once
    push_move(0, 3);
    @(negedge clk);
    increase = 1'b1; amount = AW'(3); cmd_valid = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    cmd_valid = 1'b0; increase = 1'b0; amount = '0;
    $display("cmd held 100 cycles inc=1 amt=3 code=%0d", dac_code);
    wait_drain(200, "C");
    chk("C_code", int'(dac_code), 3);
    chk("C_sat_count", sat_cnt, exp_sat);

    // D: off, target 200 while OFF, on, off mid-ramp
    push_move(3, 0);
    cmd(0, 1, 0, 0, 0);
    wait_drain(200, "D0");
    chk("D0_out_en", int'(out_en), 0);
    w0 = wr_cnt;
    cmd(0, 0, 1, 0, 197);
    repeat (4) @(negedge clk);
    chk("D0_code_off", int'(dac_code), 0);
    chk("D0_no_wr_off", wr_cnt - w0, 0);
`ifdef DAC_LEVEL_CTRL_RAMP_EN
    push_move(0, 50);
    cmd(1, 0, 0, 0, 0);
    wait_code(50, 400, "D_up");
    push_move(50, 0);
    cmd(0, 1, 0, 0, 0);
`else
    push_move(0, 200);
    cmd(1, 0, 0, 0, 0);
    wait_drain(200, "D_up");
    chk("D_code_200", int'(dac_code), 200);
    push_move(200, 0);
    cmd(0, 1, 0, 0, 0);
`endif
    wait_code(0, 400, "D_down");
    chk("D_out_en_hold", int'(out_en), 1);
    @(negedge clk);
    chk("D_out_en_drop", int'(out_en), 0);
    wait_drain(200, "D_down");

    // F: target retained on next ON, then reset mid-ramp
`ifdef DAC_LEVEL_CTRL_RAMP_EN
    push_move(0, 77);
    cmd(1, 0, 0, 0, 0);
    wait_code(77, 500, "F_up");
`else
    push_move(0, 200);
    cmd(1, 0, 0, 0, 0);
    wait_drain(200, "F_up");
    chk("F_code_200", int'(dac_code), 200);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("reset pulse cyc=%0d", cyc);
    chk("F_rst_code", int'(dac_code), 0);
    chk("F_rst_out_en", int'(out_en), 0);
    chk("F_rst_busy", int'(busy), 0);
    chk("F_rst_dac_wr", int'(dac_wr), 0);
    chk("F_rst_queue", exp_q.size(), 0);
    w0 = wr_cnt;
    cmd(1, 0, 0, 0, 0);
    chk("F_on_out_en", int'(out_en), 1);
    chk("F_on_busy", int'(busy), 0);
    repeat (8) @(negedge clk);
    chk("F_idle_code", int'(dac_code), 0);
    chk("F_idle_no_wr", wr_cnt - w0, 0);

    // E: off directly from IDLE at 0, build target 4090 while OFF, clamp to 4095
    cmd(0, 1, 0, 0, 0);
    chk("E_off_hold", int'(out_en), 1);
    @(negedge clk);
    chk("E_off_drop", int'(out_en), 0);
    for (int k = 0; k < 16; k++) cmd(0, 0, 1, 0, 255);
    cmd(0, 0, 1, 0, 10);
    chk("E_sat_none", sat_cnt, exp_sat);
    exp_sat++;
    cmd(0, 0, 1, 0, 20);
    @(negedge clk);
    chk("E_sat_4095", sat_cnt, exp_sat);
    chk("E_code_off", int'(dac_code), 0);
    push_move(0, 4095);
    cmd(1, 0, 0, 0, 0);
    wait_drain(20000, "E_up");
    chk("E_code_4095", int'(dac_code), 4095);
    chk("E_busy_done", int'(busy), 0);
    chk("E_out_en", int'(out_en), 1);
    w0 = wr_cnt;
    exp_sat++;
    cmd(0, 0, 1, 0, 1);
    repeat (6) @(negedge clk);
    chk("E_no_wrap", int'(dac_code), 4095);
    chk("E_no_wr_at_max", wr_cnt - w0, 0);
    chk("E_sat_max", sat_cnt, exp_sat);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dac_level_ctrl.md
Name: dac_level_ctrl

Overview:
- Downstream consumer of the command decoder's qualified outputs (on/off/increase/decrease/valid/amount).
- Maintains a DAC setpoint with saturating add/subtract and slews the DAC code toward it one LSB per ramp tick.
- Drives the DAC write strobe and the output-enable for the ultrasonic transmit path.

Parameters:
- AMOUNT_WIDTH, 8, width of decoder amount field.
- DAC_WIDTH, 12, DAC code width; must be >= AMOUNT_WIDTH.
- RAMP_DIV, 16, clk cycles per ramp step; >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  decoder valid (level).
- on  in  1  enable output.
- off  in  1  disable output.
- increase  in  1  raise setpoint by amount.
- decrease  in  1  lower setpoint by amount.
- amount  in  AMOUNT_WIDTH  step size, unsigned.
- dac_code  out  DAC_WIDTH  current DAC code.
- dac_wr  out  1  one-cycle strobe whenever dac_code changes.
- out_en  out  1  transmit path enable.
- busy  out  1  high in RAMP or RAMP_DOWN.
- sat  out  1  one-cycle pulse when a setpoint update clamped.

Behaviour:
- Reset (sync, rst high at posedge):
  - state=OFF; target=0.
  - dac_code, dac_wr, out_en, busy, sat, prescaler and cmd_valid_q all 0.
  - Reset applies mid-ramp; the block is fully cleared on the next edge.
- Command acceptance:
  - A command is taken only on a cmd_valid rising edge (cmd_valid=1, cmd_valid_q=0).
  - Holding cmd_valid high does not re-apply the command.
- Setpoint arithmetic, registered one cycle after acceptance:
  - amount is zero-extended to DAC_WIDTH+1 bits.
  - increase & ~decrease: target=min(target+amount, 2^DAC_WIDTH-1).
  - decrease & ~increase: target=max(target-amount, 0).
  - Both or neither set: target unchanged.
  - sat pulses 1 cycle when a clamp occurred.
- on/off fields:
  - on & ~off = ON request; off & ~on = OFF request; both set = ignored.
  - If a setpoint update and an on/off request arrive in the same command, the new target is used for the state decision.
- States:
  - OFF: out_en=0, dac_code=0.
    - ON request: out_en=1; go to RAMP if target!=0, else IDLE.
    - inc/dec update target only.
  - IDLE: out_en=1, dac_code==target.
    - Target change: go to RAMP.
    - OFF request: go to RAMP_DOWN (go directly to OFF if dac_code==0).
  - RAMP: on entry, prescaler loads RAMP_DIV-1 and decrements each cycle.
    - At 0, dac_code moves one LSB toward target, dac_wr=1 that cycle, prescaler reloads.
    - When dac_code==target after a step, go to IDLE.
    - Target change mid-ramp: continue from the current code toward the new target without restarting the prescaler.
    - OFF request: go to RAMP_DOWN.
  - RAMP_DOWN: same stepping toward 0.
    - On reaching 0, go to OFF; out_en drops on the following cycle.
    - ON request: return to RAMP.
    - target is retained for the next ON.
- Latency: first step occurs RAMP_DIV cycles after entering RAMP; a full ramp of N LSB takes N*RAMP_DIV cycles.
- Bounds: dac_code never overshoots target and never wraps.

Optional Feature:
- Macro DAC_LEVEL_CTRL_RAMP_EN.
- Defined: slew behaviour as above.
- Not defined:
  - No prescaler.
  - RAMP/RAMP_DOWN collapse: dac_code loads target (or 0 for OFF) one cycle after the state decision, with one dac_wr pulse.
  - busy stays 0.
  - out_en drops the cycle after dac_code reaches 0.

Test Plan (DAC_WIDTH=12, AMOUNT_WIDTH=8, RAMP_DIV=4):
- Reset, then cmd edge on=1, increase=1, amount=10 -> out_en=1; dac_code steps 0→10, one step every 4 cycles; exactly 10 dac_wr pulses; busy low after code 10.
- target=4090, cmd increase amount=20 -> target=4095, one sat pulse; ramp ends at 4095, no wrap.
- target=5 in IDLE, cmd decrease amount=9 -> target=0, sat pulse; code ramps down to 0; out_en stays 1.
- cmd_valid held high 100 cycles with increase amount=3 -> target increases by exactly 3.
- During ramp 0→200 at code 50, cmd off -> code ramps 50→0, state OFF, out_en low next cycle. Later on -> ramp 0→200 (target retained).
- rst pulsed at code 77 mid-ramp -> next cycle all outputs 0, state OFF, target 0; a further on command yields IDLE with code 0.
